// File: rtl/decode_issue_stage_pkg.sv
// Shared RV32I decode definitions: one-hot widths, opcode encodings and bit indices
// used by the decode/issue stage and its register file.
package decode_issue_stage_pkg;

  localparam int ALU_WIDTH       = 14;
  localparam int OPCODE_WIDTH    = 11;
  localparam int EXCEPTION_WIDTH = 3;

  typedef enum logic [6:0] {
    OPC_LOAD   = 7'b0000011,
    OPC_FENCE  = 7'b0001111,
    OPC_ITYPE  = 7'b0010011,
    OPC_AUIPC  = 7'b0010111,
    OPC_STORE  = 7'b0100011,
    OPC_RTYPE  = 7'b0110011,
    OPC_LUI    = 7'b0110111,
    OPC_BRANCH = 7'b1100011,
    OPC_JALR   = 7'b1100111,
    OPC_JAL    = 7'b1101111,
    OPC_SYSTEM = 7'b1110011
  } rv_opcode_e;

  // Bit positions within di_o_opcode
  localparam int OP_LUI    = 0;
  localparam int OP_AUIPC  = 1;
  localparam int OP_JAL    = 2;
  localparam int OP_JALR   = 3;
  localparam int OP_BRANCH = 4;
  localparam int OP_LOAD   = 5;
  localparam int OP_STORE  = 6;
  localparam int OP_ITYPE  = 7;
  localparam int OP_RTYPE  = 8;
  localparam int OP_FENCE  = 9;
  localparam int OP_SYSTEM = 10;

  // Bit positions within di_o_alu
  localparam int ALU_ADD  = 0;
  localparam int ALU_SUB  = 1;
  localparam int ALU_SLL  = 2;
  localparam int ALU_SLT  = 3;
  localparam int ALU_SLTU = 4;
  localparam int ALU_XOR  = 5;
  localparam int ALU_SRL  = 6;
  localparam int ALU_SRA  = 7;
  localparam int ALU_OR   = 8;
  localparam int ALU_AND  = 9;
  localparam int ALU_EQ   = 10;
  localparam int ALU_NE   = 11;
  localparam int ALU_GE   = 12;
  localparam int ALU_GEU  = 13;

  // Bit positions within di_o_exception
  localparam int EXC_EBREAK  = 0;
  localparam int EXC_ECALL   = 1;
  localparam int EXC_ILLEGAL = 2;

endpackage

// File: rtl/decode_issue_stage_regfile_bypass.sv
// Register file with two combinational read ports, one write port, optional
// hard-wired zero register and optional write-back-to-read bypass.
module regfile_bypass #(
  parameter int unsigned DWIDTH   = 32,
  parameter int unsigned AWIDTH   = 5,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AWIDTH-1:0] wr_addr,
  input  logic [DWIDTH-1:0] wr_data,
  input  logic [AWIDTH-1:0] rd_addr_a,
  output logic [DWIDTH-1:0] rd_data_a,
  input  logic [AWIDTH-1:0] rd_addr_b,
  output logic [DWIDTH-1:0] rd_data_b
);

  localparam int unsigned NREGS = 2 ** AWIDTH;

  logic [DWIDTH-1:0] mem [NREGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREGS; i++) mem[i] <= '0;
    end else if (we && !(ZERO_REG && wr_addr == '0)) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data_a = (ZERO_REG && rd_addr_a == '0)           ? '0      :
                     (BYPASS && we && wr_addr == rd_addr_a)  ? wr_data :
                                                               mem[rd_addr_a];

  assign rd_data_b = (ZERO_REG && rd_addr_b == '0)           ? '0      :
                     (BYPASS && we && wr_addr == rd_addr_b)  ? wr_data :
                                                               mem[rd_addr_b];

endmodule

// File: rtl/decode_issue_stage.sv
// RV32I decode/issue stage: decodes one instruction per cycle, reads operands,
// detects load-use hazards and registers everything into the ID/EX register.
module decode_issue_stage
  import decode_issue_stage_pkg::*;
#(
  parameter int unsigned DWIDTH      = 32,
  parameter int unsigned AWIDTH      = 5,
  parameter int unsigned PC_WIDTH    = 32,
  parameter int unsigned IWIDTH      = 32,
  parameter int unsigned FUNCT_WIDTH = 3,
  parameter bit          ZERO_REG    = 1'b1,
  parameter bit          BYPASS      = 1'b1,
  parameter bit          INTERLOCK   = 1'b1
) (
  input  logic                       di_clk,
  input  logic                       di_rst,
  input  logic                       di_i_ce,
  input  logic [IWIDTH-1:0]          di_i_instr,
  input  logic [PC_WIDTH-1:0]        di_i_pc,
  input  logic                       di_i_stall,
  input  logic                       di_i_flush,
  input  logic                       di_i_ex_ce,
  input  logic                       di_i_ex_load,
  input  logic [AWIDTH-1:0]          di_i_ex_rd,
  input  logic                       di_i_wb_we,
  input  logic [AWIDTH-1:0]          di_i_wb_rd,
  input  logic [DWIDTH-1:0]          di_i_wb_data,
  output logic                       di_o_ce,
  output logic [PC_WIDTH-1:0]        di_o_pc,
  output logic [AWIDTH-1:0]          di_o_rs1_addr,
  output logic [AWIDTH-1:0]          di_o_rs2_addr,
  output logic [AWIDTH-1:0]          di_o_rd_addr,
  output logic [DWIDTH-1:0]          di_o_rs1_data,
  output logic [DWIDTH-1:0]          di_o_rs2_data,
  output logic [DWIDTH-1:0]          di_o_imm,
  output logic [FUNCT_WIDTH-1:0]     di_o_funct3,
  output logic [ALU_WIDTH-1:0]       di_o_alu,
  output logic [OPCODE_WIDTH-1:0]    di_o_opcode,
  output logic [EXCEPTION_WIDTH-1:0] di_o_exception,
  output logic                       di_o_stall
);

  logic [31:0] ins;
  logic [6:0]  f7;
  logic [2:0]  f3;
  logic [AWIDTH-1:0] rs1_a, rs2_a, rd_a;
  logic [DWIDTH-1:0] rs1_d, rs2_d;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm32;
  logic [ALU_WIDTH-1:0]       dec_alu;
  logic [OPCODE_WIDTH-1:0]    dec_opc;
  logic [EXCEPTION_WIDTH-1:0] dec_exc;
  logic rs1_used, rs2_used, illegal, hazard;

  assign ins   = 32'(di_i_instr);
  assign f7    = ins[31:25];
  assign f3    = ins[14:12];
  assign rs1_a = AWIDTH'(ins[19:15]);
  assign rs2_a = AWIDTH'(ins[24:20]);
  assign rd_a  = AWIDTH'(ins[11:7]);

  assign imm_i = {{20{ins[31]}}, ins[31:20]};
  assign imm_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
  assign imm_b = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
  assign imm_u = {ins[31:12], 12'b0};
  assign imm_j = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};

  always_comb begin
    dec_alu  = '0;
    dec_opc  = '0;
    dec_exc  = '0;
    imm32    = '0;
    rs1_used = 1'b0;
    rs2_used = 1'b0;
    illegal  = 1'b0;
    case (ins[6:0])
      OPC_LUI:   begin dec_opc[OP_LUI]   = 1'b1; dec_alu[ALU_ADD] = 1'b1; imm32 = imm_u; end
      OPC_AUIPC: begin dec_opc[OP_AUIPC] = 1'b1; dec_alu[ALU_ADD] = 1'b1; imm32 = imm_u; end
      OPC_JAL:   begin dec_opc[OP_JAL]   = 1'b1; dec_alu[ALU_ADD] = 1'b1; imm32 = imm_j; end
      OPC_JALR: begin
        dec_opc[OP_JALR] = 1'b1; dec_alu[ALU_ADD] = 1'b1; imm32 = imm_i; rs1_used = 1'b1;
        illegal = (f3 != 3'b000);
      end
      OPC_BRANCH: begin
        dec_opc[OP_BRANCH] = 1'b1; imm32 = imm_b; rs1_used = 1'b1; rs2_used = 1'b1;
        case (f3)
          3'b000:  dec_alu[ALU_EQ]   = 1'b1;
          3'b001:  dec_alu[ALU_NE]   = 1'b1;
          3'b100:  dec_alu[ALU_SLT]  = 1'b1;
          3'b101:  dec_alu[ALU_GE]   = 1'b1;
          3'b110:  dec_alu[ALU_SLTU] = 1'b1;
          3'b111:  dec_alu[ALU_GEU]  = 1'b1;
          default: illegal = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        dec_opc[OP_LOAD] = 1'b1; dec_alu[ALU_ADD] = 1'b1; imm32 = imm_i; rs1_used = 1'b1;
        illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
      end
      OPC_STORE: begin
        dec_opc[OP_STORE] = 1'b1; dec_alu[ALU_ADD] = 1'b1; imm32 = imm_s;
        rs1_used = 1'b1; rs2_used = 1'b1;
        illegal = (f3 > 3'b010);
      end
      OPC_ITYPE: begin
        dec_opc[OP_ITYPE] = 1'b1; imm32 = imm_i; rs1_used = 1'b1;
        case (f3)
          3'b000: dec_alu[ALU_ADD]  = 1'b1;
          3'b010: dec_alu[ALU_SLT]  = 1'b1;
          3'b011: dec_alu[ALU_SLTU] = 1'b1;
          3'b100: dec_alu[ALU_XOR]  = 1'b1;
          3'b110: dec_alu[ALU_OR]   = 1'b1;
          3'b111: dec_alu[ALU_AND]  = 1'b1;
          3'b001: if (f7 == 7'b0000000) dec_alu[ALU_SLL] = 1'b1; else illegal = 1'b1;
          default: begin
            if (f7 == 7'b0000000)      dec_alu[ALU_SRL] = 1'b1;
            else if (f7 == 7'b0100000) dec_alu[ALU_SRA] = 1'b1;
            else                       illegal = 1'b1;
          end
        endcase
      end
      OPC_RTYPE: begin
        dec_opc[OP_RTYPE] = 1'b1; rs1_used = 1'b1; rs2_used = 1'b1;
        if (f7 == 7'b0000000) begin
          case (f3)
            3'b000:  dec_alu[ALU_ADD]  = 1'b1;
            3'b001:  dec_alu[ALU_SLL]  = 1'b1;
            3'b010:  dec_alu[ALU_SLT]  = 1'b1;
            3'b011:  dec_alu[ALU_SLTU] = 1'b1;
            3'b100:  dec_alu[ALU_XOR]  = 1'b1;
            3'b101:  dec_alu[ALU_SRL]  = 1'b1;
            3'b110:  dec_alu[ALU_OR]   = 1'b1;
            default: dec_alu[ALU_AND]  = 1'b1;
          endcase
        end else if (f7 == 7'b0100000 && f3 == 3'b000) dec_alu[ALU_SUB] = 1'b1;
        else if (f7 == 7'b0100000 && f3 == 3'b101)     dec_alu[ALU_SRA] = 1'b1;
        else illegal = 1'b1;
      end
      OPC_FENCE: begin
        dec_opc[OP_FENCE] = 1'b1;
        illegal = (f3[2:1] != 2'b00);
      end
      OPC_SYSTEM: begin
        dec_opc[OP_SYSTEM] = 1'b1;
        if (f3 == 3'b000) begin
          if (ins[31:7] == 25'd0)                    dec_exc[EXC_ECALL]  = 1'b1;
          else if (ins[31:7] == {12'h001, 13'd0})    dec_exc[EXC_EBREAK] = 1'b1;
          else                                       illegal = 1'b1;
        end else if (f3 == 3'b100) begin
          illegal = 1'b1;
        end else begin
          imm32    = {20'd0, ins[31:20]};
          rs1_used = !f3[2];
        end
      end
      default: illegal = 1'b1;
    endcase
    if (illegal) begin
      dec_alu  = '0;
      dec_opc  = '0;
      dec_exc  = '0;
      imm32    = '0;
      rs1_used = 1'b0;
      rs2_used = 1'b0;
      dec_exc[EXC_ILLEGAL] = 1'b1;
    end
  end

  regfile_bypass #(
    .DWIDTH  (DWIDTH),
    .AWIDTH  (AWIDTH),
    .ZERO_REG(ZERO_REG),
    .BYPASS  (BYPASS)
  ) u_regfile (
    .clk      (di_clk),
    .rst      (di_rst),
    .we       (di_i_wb_we),
    .wr_addr  (di_i_wb_rd),
    .wr_data  (di_i_wb_data),
    .rd_addr_a(rs1_a),
    .rd_data_a(rs1_d),
    .rd_addr_b(rs2_a),
    .rd_data_b(rs2_d)
  );

  assign hazard = INTERLOCK && di_i_ce && di_i_ex_ce && di_i_ex_load && (di_i_ex_rd != '0) &&
                  ((rs1_used && rs1_a == di_i_ex_rd) || (rs2_used && rs2_a == di_i_ex_rd));

  assign di_o_stall = !di_rst && !di_i_flush && (di_i_stall || hazard);

  always_ff @(posedge di_clk) begin
    if (di_rst) begin
      di_o_ce        <= 1'b0;
      di_o_pc        <= '0;
      di_o_rs1_addr  <= '0;
      di_o_rs2_addr  <= '0;
      di_o_rd_addr   <= '0;
      di_o_rs1_data  <= '0;
      di_o_rs2_data  <= '0;
      di_o_imm       <= '0;
      di_o_funct3    <= '0;
      di_o_alu       <= '0;
      di_o_opcode    <= '0;
      di_o_exception <= '0;
    end else if (di_i_flush) begin
      di_o_ce <= 1'b0;
    end else if (di_i_stall) begin
      // Held operands must track write-back, or EX would consume stale data after release.
      if (di_i_wb_we && di_i_wb_rd == di_o_rs1_addr && (di_o_rs1_addr != '0 || !ZERO_REG))
        di_o_rs1_data <= di_i_wb_data;
      if (di_i_wb_we && di_i_wb_rd == di_o_rs2_addr && (di_o_rs2_addr != '0 || !ZERO_REG))
        di_o_rs2_data <= di_i_wb_data;
    end else if (hazard) begin
      di_o_ce <= 1'b0;
    end else begin
      di_o_ce        <= di_i_ce;
      di_o_pc        <= di_i_pc;
      di_o_rs1_addr  <= rs1_a;
      di_o_rs2_addr  <= rs2_a;
      di_o_rd_addr   <= rd_a;
      di_o_rs1_data  <= rs1_d;
      di_o_rs2_data  <= rs2_d;
      di_o_imm       <= DWIDTH'($signed(imm32));
      di_o_funct3    <= FUNCT_WIDTH'(f3);
      di_o_alu       <= dec_alu;
      di_o_opcode    <= dec_opc;
      di_o_exception <= dec_exc;
    end
  end

endmodule

// File: tb/tb_decode_issue_stage.sv
// Scoreboard bench for decode_issue_stage: stimulus queues expected ID/EX contents,
// a monitor pops and compares on every valid output cycle.
module tb_decode_issue_stage;
  import decode_issue_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce = 1'b0;
  logic [31:0] instr = '0;
  logic [31:0] pc = '0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        ex_ce = 1'b0;
  logic        ex_load = 1'b0;
  logic [4:0]  ex_rd = '0;
  logic        wb_we = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic [31:0] wb_data = '0;

  logic        o_ce, o_stall;
  logic [31:0] o_pc, o_rs1d, o_rs2d, o_imm;
  logic [4:0]  o_rs1a, o_rs2a, o_rd;
  logic [2:0]  o_f3, o_exc;
  logic [13:0] o_alu;
  logic [10:0] o_opc;

  logic        nb_ce, nb_stall;
  logic [31:0] nb_pc, nb_rs1d, nb_rs2d, nb_imm;
  logic [4:0]  nb_rs1a, nb_rs2a, nb_rd;
  logic [2:0]  nb_f3, nb_exc;
  logic [13:0] nb_alu;
  logic [10:0] nb_opc;

  decode_issue_stage dut (
    .di_clk(clk), .di_rst(rst), .di_i_ce(ce), .di_i_instr(instr), .di_i_pc(pc),
    .di_i_stall(stall), .di_i_flush(flush), .di_i_ex_ce(ex_ce), .di_i_ex_load(ex_load),
    .di_i_ex_rd(ex_rd), .di_i_wb_we(wb_we), .di_i_wb_rd(wb_rd), .di_i_wb_data(wb_data),
    .di_o_ce(o_ce), .di_o_pc(o_pc), .di_o_rs1_addr(o_rs1a), .di_o_rs2_addr(o_rs2a),
    .di_o_rd_addr(o_rd), .di_o_rs1_data(o_rs1d), .di_o_rs2_data(o_rs2d), .di_o_imm(o_imm),
    .di_o_funct3(o_f3), .di_o_alu(o_alu), .di_o_opcode(o_opc), .di_o_exception(o_exc),
    .di_o_stall(o_stall)
  );

  decode_issue_stage #(.BYPASS(1'b0)) dut_nb (
    .di_clk(clk), .di_rst(rst), .di_i_ce(ce), .di_i_instr(instr), .di_i_pc(pc),
    .di_i_stall(stall), .di_i_flush(flush), .di_i_ex_ce(ex_ce), .di_i_ex_load(ex_load),
    .di_i_ex_rd(ex_rd), .di_i_wb_we(wb_we), .di_i_wb_rd(wb_rd), .di_i_wb_data(wb_data),
    .di_o_ce(nb_ce), .di_o_pc(nb_pc), .di_o_rs1_addr(nb_rs1a), .di_o_rs2_addr(nb_rs2a),
    .di_o_rd_addr(nb_rd), .di_o_rs1_data(nb_rs1d), .di_o_rs2_data(nb_rs2d), .di_o_imm(nb_imm),
    .di_o_funct3(nb_f3), .di_o_alu(nb_alu), .di_o_opcode(nb_opc), .di_o_exception(nb_exc),
    .di_o_stall(nb_stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  rs1a, rs2a, rd;
    logic [31:0] rs1d, rs2d, imm;
    logic [2:0]  f3;
    logic [13:0] alu;
    logic [10:0] opc;
    logic [2:0]  exc;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad = 0;

  localparam logic [13:0] A_ADD    = 14'd1 << ALU_ADD;
  localparam logic [10:0] C_ITYPE  = 11'd1 << OP_ITYPE;
  localparam logic [10:0] C_RTYPE  = 11'd1 << OP_RTYPE;
  localparam logic [10:0] C_STORE  = 11'd1 << OP_STORE;
  localparam logic [10:0] C_LUI    = 11'd1 << OP_LUI;
  localparam logic [10:0] C_SYSTEM = 11'd1 << OP_SYSTEM;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic push(input logic [31:0] p, input logic [4:0] r1a, input logic [4:0] r2a,
                      input logic [4:0] rd, input logic [31:0] r1d, input logic [31:0] r2d,
                      input logic [31:0] imm, input logic [2:0] f3, input logic [13:0] alu,
                      input logic [10:0] opc, input logic [2:0] exc);
    exp_t e;
    e.pc = p; e.rs1a = r1a; e.rs2a = r2a; e.rd = rd; e.rs1d = r1d; e.rs2d = r2d;
    e.imm = imm; e.f3 = f3; e.alu = alu; e.opc = opc; e.exc = exc;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ce"},   64'(o_ce),   64'd0);
    chk({tag, "_pc"},   64'(o_pc),   64'd0);
    chk({tag, "_addr"}, 64'({o_rs1a, o_rs2a, o_rd}), 64'd0);
    chk({tag, "_data"}, {o_rs1d, o_rs2d}, 64'd0);
    chk({tag, "_imm"},  64'(o_imm),  64'd0);
    chk({tag, "_ctl"},  64'({o_f3, o_alu, o_opc, o_exc}), 64'd0);
  endtask

  // Monitor: every valid ID/EX cycle must match the next queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (o_ce === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", {32'd0, o_pc}, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("pc",   64'(o_pc),   64'(e.pc));
          chk("rs1a", 64'(o_rs1a), 64'(e.rs1a));
          chk("rs2a", 64'(o_rs2a), 64'(e.rs2a));
          chk("rd",   64'(o_rd),   64'(e.rd));
          chk("rs1d", 64'(o_rs1d), 64'(e.rs1d));
          chk("rs2d", 64'(o_rs2d), 64'(e.rs2d));
          chk("imm",  64'(o_imm),  64'(e.imm));
          chk("f3",   64'(o_f3),   64'(e.f3));
          chk("alu",  64'(o_alu),  64'(e.alu));
          chk("opc",  64'(o_opc),  64'(e.opc));
          chk("exc",  64'(o_exc),  64'(e.exc));
        end
      end
    end
  end

  initial begin
    // Reset with downstream stall asserted: stall request must stay low
    rst = 1'b1; stall = 1'b1;
    step();
    chk("rst_stall", 64'(o_stall), 64'd0);
    step();
    chk_all_zero("rst0");
    rst = 1'b0; stall = 1'b0;

    // ADDI x5, x0, 7
    ce = 1'b1; pc = 32'h40; instr = 32'h0070_0293;
    push(32'h40, 5'd0, 5'd7, 5'd5, 32'd0, 32'd0, 32'd7, 3'd0, A_ADD, C_ITYPE, 3'b000);
    step();

    // ADD x4, x3, x3 with same-cycle write-back x3 = DEADBEEF
    pc = 32'h44; instr = 32'h0031_8233;
    wb_we = 1'b1; wb_rd = 5'd3; wb_data = 32'hDEAD_BEEF;
    push(32'h44, 5'd3, 5'd3, 5'd4, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'd0, 3'd0, A_ADD, C_RTYPE, 3'b000);
    step();
    chk("nobypass_rs1d", 64'(nb_rs1d), 64'd0);
    chk("nobypass_rs2d", 64'(nb_rs2d), 64'd0);
    wb_we = 1'b0;

    // Load-use: EX is LW x6, decode ADD x7, x6, x1
    ex_ce = 1'b1; ex_load = 1'b1; ex_rd = 5'd6;
    pc = 32'h48; instr = 32'h0013_03B3;
    #1 chk("hazard_stall", 64'(o_stall), 64'd1);
    step();
    chk("bubble_ce", 64'(o_ce), 64'd0);
    ex_ce = 1'b0;
    #1 chk("hazard_clear", 64'(o_stall), 64'd0);
    push(32'h48, 5'd6, 5'd1, 5'd7, 32'd0, 32'd0, 32'd0, 3'd0, A_ADD, C_RTYPE, 3'b000);
    step();

    // EX load to x0 never interlocks
    ex_ce = 1'b1; ex_load = 1'b1; ex_rd = 5'd0;
    pc = 32'h4C; instr = 32'h0010_03B3;
    #1 chk("exrd0_nostall", 64'(o_stall), 64'd0);
    push(32'h4C, 5'd0, 5'd1, 5'd7, 32'd0, 32'd0, 32'd0, 3'd0, A_ADD, C_RTYPE, 3'b000);
    step();
    ex_ce = 1'b0; ex_load = 1'b0;

    // ADD x8, x2, x1, then hold 3 cycles; WB x1 = 0x55 refreshes rs2 data
    pc = 32'h50; instr = 32'h0011_0433;
    push(32'h50, 5'd2, 5'd1, 5'd8, 32'd0, 32'd0, 32'd0, 3'd0, A_ADD, C_RTYPE, 3'b000);
    step();
    stall = 1'b1; pc = 32'h99; instr = 32'h0070_0293;
    wb_we = 1'b1; wb_rd = 5'd1; wb_data = 32'h55;
    #1 chk("hold_stall", 64'(o_stall), 64'd1);
    for (int i = 0; i < 3; i++) begin
      push(32'h50, 5'd2, 5'd1, 5'd8, 32'd0, 32'h55, 32'd0, 3'd0, A_ADD, C_RTYPE, 3'b000);
      step();
      wb_we = 1'b0;
    end
    stall = 1'b0;

    // ADD x9, x1, x3 reads the written registers
    pc = 32'h54; instr = 32'h0030_84B3;
    push(32'h54, 5'd1, 5'd3, 5'd9, 32'h55, 32'hDEAD_BEEF, 32'd0, 3'd0, A_ADD, C_RTYPE, 3'b000);
    step();

    // Flush together with a hazard
    flush = 1'b1; ex_ce = 1'b1; ex_load = 1'b1; ex_rd = 5'd6;
    pc = 32'h58; instr = 32'h0013_03B3;
    #1 chk("flush_stall", 64'(o_stall), 64'd0);
    step();
    chk("flush_ce", 64'(o_ce), 64'd0);
    flush = 1'b0; ex_ce = 1'b0; ex_load = 1'b0;

    // Illegal opcode 0x7F
    pc = 32'h60; instr = 32'h0000_007F;
    push(32'h60, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 3'd0, 14'd0, 11'd0, 3'b100);
    step();

    // Write to x0 is ignored and not bypassed; ADD x10, x0, x0
    pc = 32'h64; instr = 32'h0000_0533;
    wb_we = 1'b1; wb_rd = 5'd0; wb_data = 32'h1234;
    push(32'h64, 5'd0, 5'd0, 5'd10, 32'd0, 32'd0, 32'd0, 3'd0, A_ADD, C_RTYPE, 3'b000);
    step();
    wb_we = 1'b0; pc = 32'h68;
    push(32'h68, 5'd0, 5'd0, 5'd10, 32'd0, 32'd0, 32'd0, 3'd0, A_ADD, C_RTYPE, 3'b000);
    step();

    // SW x2, -4(x1): S-format negative immediate
    pc = 32'h6C; instr = 32'hFE20_AE23;
    push(32'h6C, 5'd1, 5'd2, 5'd28, 32'h55, 32'd0, 32'hFFFF_FFFC, 3'd2, A_ADD, C_STORE, 3'b000);
    step();

    // LUI x11, 0x12345 with EX load to its rs1 field: no operands used, no stall
    ex_ce = 1'b1; ex_load = 1'b1; ex_rd = 5'd8;
    pc = 32'h70; instr = 32'h1234_55B7;
    #1 chk("lui_nostall", 64'(o_stall), 64'd0);
    push(32'h70, 5'd8, 5'd3, 5'd11, 32'd0, 32'hDEAD_BEEF, 32'h1234_5000, 3'd5, A_ADD, C_LUI, 3'b000);
    step();
    ex_ce = 1'b0; ex_load = 1'b0;

    // ECALL while write-back sets x5 = 0xABCD
    pc = 32'h74; instr = 32'h0000_0073;
    wb_we = 1'b1; wb_rd = 5'd5; wb_data = 32'h0000_ABCD;
    push(32'h74, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 3'd0, 14'd0, C_SYSTEM, 3'b010);
    step();
    wb_we = 1'b0;

    // ADD x12, x5, x5
    pc = 32'h78; instr = 32'h0052_8633;
    push(32'h78, 5'd5, 5'd5, 5'd12, 32'h0000_ABCD, 32'h0000_ABCD, 32'd0, 3'd0, A_ADD, C_RTYPE, 3'b000);
    step();

    // MUL encoding (funct7 = 1) is illegal in RV32I
    pc = 32'h7C; instr = 32'h0220_8033;
    push(32'h7C, 5'd1, 5'd2, 5'd0, 32'h55, 32'd0, 32'd0, 3'd0, 14'd0, 11'd0, 3'b100);
    step();

    // Mid-stream reset, then x5 must read back as 0
    rst = 1'b1; stall = 1'b1; pc = 32'h80; instr = 32'h0052_8633;
    #1 chk("rst_mid_stall", 64'(o_stall), 64'd0);
    step();
    chk_all_zero("rst1");
    rst = 1'b0; stall = 1'b0; pc = 32'h84;
    push(32'h84, 5'd5, 5'd5, 5'd12, 32'd0, 32'd0, 32'd0, 3'd0, A_ADD, C_RTYPE, 3'b000);
    step();
    ce = 1'b0;
    step();
    @(negedge clk);
    #1;
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
